sdr_sample_capture: RTL and testbench

//  Avalon-ST sink for decimated I/Q samples. Packs each sample pair into one 32-bit word and

---
 rtl/sdr_capture_pkg.sv | 21 ++
 rtl/sdr_capture_csr.sv | 89 ++++++++
 rtl/sdr_sample_capture.sv | 122 ++++++++++++
 tb/tb_sdr_sample_capture.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdr_capture_pkg.sv
// Shared CSR map and FSM encoding for the I/Q sample capture block.
package sdr_capture_pkg;

  localparam logic [1:0] CSR_CTRL   = 2'd0;
  localparam logic [1:0] CSR_LENGTH = 2'd1;
  localparam logic [1:0] CSR_STATUS = 2'd2;
  localparam logic [1:0] CSR_WPTR   = 2'd3;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_RING   = 2;
  localparam int CTRL_IRQ_EN = 3;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_OVERRUN = 2;
  localparam int ST_WRAPPED = 3;

  typedef enum logic [1:0] {S_IDLE, S_CAPT, S_DRAIN, S_DONE} state_t;

endpackage

// File: rtl/sdr_capture_csr.sv
// CSR register file: CTRL/LENGTH/STATUS/WPTR, W1 pulses, W1C status, read mux.
module sdr_capture_csr
  import sdr_capture_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        csr_address,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  input  logic              csr_read,
  output logic [31:0]       csr_readdata,
  input  logic              busy,
  input  logic [ADDR_W-1:0] wptr,
  input  logic              clr_status,
  input  logic              set_done,
  input  logic              set_overrun,
  input  logic              set_wrapped,
  output logic              start,
  output logic              abort,
  output logic              ring,
  output logic              irq_en,
  output logic [ADDR_W:0]   length,
  output logic              irq
);

  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  logic done, overrun, wrapped;
  logic wr_ctrl, wr_len, wr_stat;

  assign wr_ctrl = csr_write && (csr_address == CSR_CTRL);
  assign wr_len  = csr_write && (csr_address == CSR_LENGTH);
  assign wr_stat = csr_write && (csr_address == CSR_STATUS);

  // start/abort are write-one pulses; they never read back as set
  assign start = wr_ctrl && csr_writedata[CTRL_START];
  assign abort = wr_ctrl && csr_writedata[CTRL_ABORT];
  assign irq   = done && irq_en;

  // Control, length and sticky status; hardware set wins over a same-cycle W1C
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ring    <= 1'b0;
      irq_en  <= 1'b0;
      length  <= FULL;
      done    <= 1'b0;
      overrun <= 1'b0;
      wrapped <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        irq_en <= csr_writedata[CTRL_IRQ_EN];
        if (!busy) ring <= csr_writedata[CTRL_RING];
      end
      // 0 and anything above the RAM depth collapse to the full depth
      if (wr_len && !busy)
        length <= (csr_writedata == 32'd0 || csr_writedata > 32'(FULL)) ?
                  FULL : csr_writedata[ADDR_W:0];
      if (clr_status) begin
        done    <= 1'b0;
        overrun <= 1'b0;
        wrapped <= 1'b0;
      end else begin
        if (wr_stat && csr_writedata[ST_DONE])    done    <= 1'b0;
        if (wr_stat && csr_writedata[ST_OVERRUN]) overrun <= 1'b0;
        if (wr_stat && csr_writedata[ST_WRAPPED]) wrapped <= 1'b0;
        if (set_done)    done    <= 1'b1;
        if (set_overrun) overrun <= 1'b1;
        if (set_wrapped) wrapped <= 1'b1;
      end
    end
  end

  // Registered read data, one cycle after csr_read
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      csr_readdata <= 32'd0;
    end else if (csr_read) begin
      case (csr_address)
        CSR_CTRL:   csr_readdata <= {28'd0, irq_en, ring, 2'b00};
        CSR_LENGTH: csr_readdata <= 32'(length);
        CSR_STATUS: csr_readdata <= {28'd0, wrapped, overrun, done, busy};
        default:    csr_readdata <= 32'(wptr);
      endcase
    end
  end

endmodule

// File: rtl/sdr_sample_capture.sv
// Avalon-ST I/Q sink packing sample pairs into 32-bit words written to RAM
// through an Avalon-MM master; one-shot or ring capture under CSR control.
module sdr_sample_capture
  import sdr_capture_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                snk_valid,
  output logic                snk_ready,
  input  logic [SAMPLE_W-1:0] snk_i,
  input  logic [SAMPLE_W-1:0] snk_q,
  input  logic [1:0]          csr_address,
  input  logic                csr_write,
  input  logic [31:0]         csr_writedata,
  input  logic                csr_read,
  output logic [31:0]         csr_readdata,
  output logic [ADDR_W-1:0]   m_address,
  output logic [3:0]          m_byteenable,
  output logic                m_chipselect,
  output logic                m_write,
  output logic [31:0]         m_writedata,
  input  logic                m_waitrequest,
  output logic                irq
);

  state_t            state;
  logic              pend;
  logic [31:0]       held;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W:0]   count, acnt, length;
  logic              start, abort, ring, irq_en;
  logic              capt, busy, wr_done, cap, accept, go;
  logic              last_ring, last_one, set_done, set_overrun, set_wrapped;
  logic [31:0]       word;

  assign capt    = (state == S_CAPT);
  assign busy    = capt || (state == S_DRAIN);
  assign wr_done = pend && !m_waitrequest;
  // one-shot stops taking samples once LENGTH have been accepted
  assign cap     = !ring && (acnt >= length);
  assign snk_ready = capt ? (!pend || wr_done) : 1'b1;
  assign accept  = capt && snk_valid && snk_ready && !cap;
  assign go      = start && !abort && (state == S_IDLE || state == S_DONE);

  assign last_ring   = ring && ({1'b0, wptr} == length - 1'b1);
  assign last_one    = !ring && ((count + 1'b1) == length);
  assign set_done    = wr_done && last_one && capt && !abort;
  assign set_wrapped = wr_done && last_ring;
  assign set_overrun = capt && snk_valid && !snk_ready;

  assign word = {16'($signed(snk_q)), 16'($signed(snk_i))};

  assign m_write      = pend;
  assign m_chipselect = pend;
  assign m_address    = wptr;
  assign m_writedata  = held;
  assign m_byteenable = 4'hF;

  // FSM, single-entry holding register and write pointer / counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
      pend  <= 1'b0;
      held  <= 32'd0;
      wptr  <= '0;
      count <= '0;
      acnt  <= '0;
    end else begin
      if (go) begin
        wptr  <= '0;
        count <= '0;
        acnt  <= '0;
      end else begin
        if (wr_done) begin
          wptr  <= last_ring ? '0 : wptr + 1'b1;
          count <= count + 1'b1;
        end
        if (accept) acnt <= acnt + 1'b1;
      end
      if (accept) begin
        pend <= 1'b1;
        held <= word;
      end else if (wr_done) begin
        pend <= 1'b0;
      end
      case (state)
        S_IDLE:  if (go) state <= S_CAPT;
        S_CAPT:  if (abort) state <= S_DRAIN;
                 else if (set_done) state <= S_DONE;
        S_DRAIN: if (!pend || !m_waitrequest) state <= S_IDLE;
        S_DONE:  if (go) state <= S_CAPT;
        default: state <= S_IDLE;
      endcase
    end
  end

  sdr_capture_csr #(.ADDR_W(ADDR_W)) u_csr (
    .clk          (clk),
    .reset_n      (reset_n),
    .csr_address  (csr_address),
    .csr_write    (csr_write),
    .csr_writedata(csr_writedata),
    .csr_read     (csr_read),
    .csr_readdata (csr_readdata),
    .busy         (busy),
    .wptr         (wptr),
    .clr_status   (go),
    .set_done     (set_done),
    .set_overrun  (set_overrun),
    .set_wrapped  (set_wrapped),
    .start        (start),
    .abort        (abort),
    .ring         (ring),
    .irq_en       (irq_en),
    .length       (length),
    .irq          (irq)
  );

endmodule

// File: tb/tb_sdr_sample_capture.sv
// Directed bench for sdr_sample_capture: one-shot, backpressure, ring, abort,
// full-depth and mid-capture reset, with a write log taken off the master port.
module tb_sdr_sample_capture;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        snk_valid = 1'b0;
  logic        snk_ready;
  logic [15:0] snk_i = '0, snk_q = '0;
  logic [1:0]  csr_address = '0;
  logic        csr_write = 1'b0;
  logic [31:0] csr_writedata = '0;
  logic        csr_read = 1'b0;
  logic [31:0] csr_readdata;
  logic [11:0] m_address;
  logic [3:0]  m_byteenable;
  logic        m_chipselect, m_write;
  logic [31:0] m_writedata;
  logic        m_waitrequest = 1'b0;
  logic        irq;

  int checks = 0, errors = 0;
  logic ws_mode = 1'b0, hold_wait = 1'b0;
  int wcnt = 0;
  logic [31:0] wdat[$];
  logic [11:0] wadr[$];
  logic [31:0] rd;

  sdr_sample_capture dut (
    .clk(clk), .reset_n(reset_n), .snk_valid(snk_valid), .snk_ready(snk_ready),
    .snk_i(snk_i), .snk_q(snk_q), .csr_address(csr_address), .csr_write(csr_write),
    .csr_writedata(csr_writedata), .csr_read(csr_read), .csr_readdata(csr_readdata),
    .m_address(m_address), .m_byteenable(m_byteenable), .m_chipselect(m_chipselect),
    .m_write(m_write), .m_writedata(m_writedata), .m_waitrequest(m_waitrequest),
    .irq(irq)
  );

  always #5 clk = ~clk;

  // Completed writes (m_write & !waitrequest just before the edge)
  always @(negedge clk)
    if (reset_n && m_write && !m_waitrequest) begin
      wdat.push_back(m_writedata);
      wadr.push_back(m_address);
    end

  // Waitrequest source: forced stall, or 3 stall cycles per write
  always @(posedge clk) begin
    #1;
    if (hold_wait) m_waitrequest = 1'b1;
    else if (ws_mode && m_write) begin
      if (wcnt < 3) begin m_waitrequest = 1'b1; wcnt++; end
      else begin m_waitrequest = 1'b0; wcnt = 0; end
    end else begin
      m_waitrequest = 1'b0;
      wcnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    csr_address = a; csr_writedata = d; csr_write = 1'b1;
    @(posedge clk); #1;
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    csr_address = a; csr_read = 1'b1;
    @(posedge clk); #1;
    csr_read = 1'b0;
    d = csr_readdata;
  endtask

  // Present one pair and hold it until the sink takes it; valid stays high
  task automatic send(input logic [15:0] i, input logic [15:0] q);
    bit acc = 1'b0;
    snk_i = i; snk_q = q; snk_valid = 1'b1;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk); acc = snk_ready;
      @(posedge clk); #1;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] exp1[4] = '{32'hFFFF_0001, 32'hFFFE_0002, 32'hFFFD_0003, 32'hFFFC_0004};
  logic [11:0] exp3[7] = '{12'd0, 12'd1, 12'd2, 12'd0, 12'd1, 12'd2, 12'd0};

  initial begin
    // reset state
    idle(3);
    chk("rst_m_write", 32'(m_write), 32'd0);
    chk("rst_m_cs", 32'(m_chipselect), 32'd0);
    chk("rst_ready", 32'(snk_ready), 32'd1);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rdata", csr_readdata, 32'd0);
    chk("rst_addr", 32'(m_address), 32'd0);
    chk("rst_be", 32'(m_byteenable), 32'hF);
    reset_n = 1'b1;
    idle(1);
    csr_rd(2'd0, rd); chk("rst_ctrl", rd, 32'd0);
    csr_rd(2'd1, rd); chk("rst_length", rd, 32'h1000);
    csr_rd(2'd2, rd); chk("rst_status", rd, 32'd0);
    csr_rd(2'd3, rd); chk("rst_wptr", rd, 32'd0);

    // 1: one-shot LENGTH=4, zero wait
    csr_wr(2'd1, 32'd4);
    csr_wr(2'd0, 32'h9);
    for (int k = 1; k <= 4; k++) send(16'(k), 16'(-k));
    snk_valid = 1'b0;
    idle(3);
    chk("t1_nwr", wdat.size(), 32'd4);
    for (int k = 0; k < 4 && k < wdat.size(); k++) begin
      chk("t1_word", wdat[k], exp1[k]);
      chk("t1_addr", 32'(wadr[k]), 32'(k));
    end
    csr_rd(2'd2, rd); chk("t1_status", rd, 32'h2);
    chk("t1_irq", 32'(irq), 32'd1);
    csr_rd(2'd3, rd); chk("t1_wptr", rd, 32'd4);

    // 2: LENGTH=8 with 3 stall cycles per write, valid held throughout
    wdat.delete(); wadr.delete();
    csr_wr(2'd1, 32'd8);
    csr_wr(2'd0, 32'h1);
    chk("t2_irq_clr", 32'(irq), 32'd0);
    ws_mode = 1'b1;
    for (int k = 0; k < 8; k++) send(16'h0100 + 16'(k), 16'h8000 + 16'(k));
    snk_valid = 1'b0;
    idle(10);
    ws_mode = 1'b0;
    chk("t2_nwr", wdat.size(), 32'd8);
    for (int k = 0; k < 8 && k < wdat.size(); k++) begin
      chk("t2_word", wdat[k], {16'h8000 + 16'(k), 16'h0100 + 16'(k)});
      chk("t2_addr", 32'(wadr[k]), 32'(k));
    end
    csr_rd(2'd2, rd); chk("t2_status", rd, 32'h6);
    chk("t2_irq_off", 32'(irq), 32'd0);

    // 3: ring LENGTH=3, 7 pairs
    wdat.delete(); wadr.delete();
    csr_wr(2'd1, 32'd3);
    csr_wr(2'd0, 32'h5);
    for (int k = 0; k < 7; k++) send(16'(k + 1), 16'd0);
    snk_valid = 1'b0;
    idle(3);
    chk("t3_nwr", wdat.size(), 32'd7);
    for (int k = 0; k < 7 && k < wadr.size(); k++) chk("t3_addr", 32'(wadr[k]), 32'(exp3[k]));
    csr_rd(2'd2, rd); chk("t3_status", rd, 32'h9);
    csr_rd(2'd3, rd); chk("t3_wptr", rd, 32'd1);
    csr_wr(2'd0, 32'h2);
    idle(2);
    csr_rd(2'd2, rd); chk("t3_stopped", rd, 32'h8);
    csr_wr(2'd0, 32'h0);

    // 4: abort while a write is stalled
    wdat.delete(); wadr.delete();
    csr_wr(2'd1, 32'd8);
    csr_wr(2'd0, 32'h1);
    hold_wait = 1'b1;
    idle(1);
    send(16'h0055, 16'h00AA);
    snk_valid = 1'b0;
    idle(2);
    chk("t4_held", 32'(m_write), 32'd1);
    csr_wr(2'd0, 32'h2);
    csr_rd(2'd2, rd); chk("t4_drain_busy", rd, 32'h1);
    chk("t4_still_held", 32'(m_write), 32'd1);
    hold_wait = 1'b0;
    idle(3);
    chk("t4_nwr", wdat.size(), 32'd1);
    if (wdat.size() > 0) chk("t4_word", wdat[0], 32'h00AA_0055);
    csr_rd(2'd2, rd); chk("t4_status", rd, 32'h0);
    send(16'h0001, 16'h0001);
    snk_valid = 1'b0;
    idle(3);
    chk("t4_no_more", wdat.size(), 32'd1);

    // 5: LENGTH=0 -> full 4096-word one-shot
    wdat.delete(); wadr.delete();
    csr_wr(2'd1, 32'd0);
    csr_rd(2'd1, rd); chk("t5_length", rd, 32'h1000);
    csr_wr(2'd0, 32'h1);
    for (int n = 0; n < 4095; n++) send(16'(n), ~16'(n));
    snk_valid = 1'b0;
    idle(3);
    csr_rd(2'd2, rd); chk("t5_not_done", rd, 32'h1);
    chk("t5_nwr4095", wdat.size(), 32'd4095);
    send(16'h0FFF, 16'hF000);
    snk_valid = 1'b0;
    idle(3);
    csr_rd(2'd2, rd); chk("t5_done", rd, 32'h2);
    chk("t5_nwr", wdat.size(), 32'd4096);
    if (wadr.size() > 0) begin
      chk("t5_first_addr", 32'(wadr[0]), 32'd0);
      chk("t5_last_addr", 32'(wadr[wadr.size()-1]), 32'hFFF);
      chk("t5_last_word", wdat[wdat.size()-1], 32'hF000_0FFF);
    end
    csr_rd(2'd3, rd); chk("t5_wptr", rd, 32'd0);

    // 6: one-cycle reset mid-capture
    wdat.delete(); wadr.delete();
    csr_wr(2'd1, 32'd8);
    csr_wr(2'd0, 32'h1);
    hold_wait = 1'b1;
    idle(1);
    send(16'h0001, 16'h0001);
    idle(2);
    snk_valid = 1'b0;
    csr_rd(2'd2, rd); chk("t6_pre_status", rd, 32'h5);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    chk("t6_m_write", 32'(m_write), 32'd0);
    chk("t6_ready", 32'(snk_ready), 32'd1);
    hold_wait = 1'b0;
    csr_rd(2'd2, rd); chk("t6_status", rd, 32'h0);
    csr_rd(2'd3, rd); chk("t6_wptr", rd, 32'd0);
    chk("t6_nwr", wdat.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
